move_parser: RTL
================

MOVE_PARSER -- requirements
Module: move_parser

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000000, meaning the idle cycles allowed between bytes of one move (1 s at 50 MHz).
REQ-002 The block SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port rx_data, input, 8, an ASCII byte from the upstream serial receiver.
REQ-005 The block SHALL have port rx_valid, input, 1, a one-cycle strobe marking rx_data valid.
REQ-006 The block SHALL have port clear, input, 1, which discards the latched move.
REQ-007 The block SHALL have ports from_file, from_rank, to_file and to_rank, each output, 4, carrying 0-7 for a move square field or 4'hF for blank.
REQ-008 The block SHALL have port move_valid, output, 1, held high while a move is latched.
REQ-009 The block SHALL have port move_pulse, output, 1, a one-cycle pulse when a new move is latched.
REQ-010 The block SHALL have port error, output, 1, a one-cycle pulse when a move is rejected.
REQ-011 The block SHALL have port busy, output, 1, high while a move is partially received.

Function
REQ-012 The block SHALL accept the move format <file><rank><file><rank><term>.
- file: 'a'-'h' or 'A'-'H', mapped to 0-7.
- rank: '1'-'8', mapped to 0-7.
- term: LF (0x0A) or CR (0x0D).
REQ-013 The FSM SHALL have states S_FFILE (idle), S_FRANK, S_TFILE, S_TRANK and S_TERM; each valid byte advances one state, and a valid term in S_TERM commits and returns to S_FFILE.
REQ-014 A term byte in S_FFILE SHALL be ignored without error, so CRLF and blank lines are harmless.
REQ-015 An invalid byte in any state other than S_FFILE SHALL pulse error, return to S_FFILE and leave the latched move unchanged.
REQ-016 A non-term, non-file byte in S_FFILE SHALL pulse error.
REQ-017 A commit where the from-square equals the to-square SHALL be rejected with an error pulse and no latch.
REQ-018 On commit, the four outputs SHALL update and move_pulse SHALL assert on the cycle after the clock edge that samples the term byte (one-cycle latency); error SHALL have the same latency.
REQ-019 Partial fields SHALL be held in internal shadow registers, and the outputs SHALL change only on commit, clear or reset.
REQ-020 move_valid SHALL rise with move_pulse and stay high until clear or reset; a new commit SHALL overwrite the previous move.
REQ-021 clear SHALL set all four outputs to 4'hF and move_valid to 0 on the next edge; the FSM state SHALL be unaffected.
REQ-022 If clear and a commit occur on the same edge, clear SHALL win, move_pulse SHALL stay 0 and the FSM SHALL still return to S_FFILE.
REQ-023 The timeout counter SHALL run only while busy, reset on every rx_valid, and on reaching TIMEOUT_CYCLES-1 pulse error and return the FSM to S_FFILE.
REQ-024 If a timeout and rx_valid occur on the same cycle, the byte SHALL take priority and the counter SHALL restart.
REQ-025 busy SHALL equal (state != S_FFILE).
REQ-026 rx_valid held high for several cycles SHALL be treated as one byte per cycle.

Reset
REQ-027 reset SHALL force, on the next edge, state S_FFILE, all four outputs 4'hF, move_valid, move_pulse and error 0, timeout counter 0 and shadow registers 0.
REQ-028 reset SHALL take priority over clear, rx_valid and timeout, including mid-move, with no error pulse.

Structure
REQ-029 A shared header move_defs.vh SHALL hold the state encodings, the ASCII constants (LF, CR, 'a', 'A', '1') and BLANK_CODE = 4'hF.
REQ-030 Exactly one sub-module, timeout_counter, SHALL be instantiated, with inputs clock, reset, enable and restart, output expired, and parameter TIMEOUT_CYCLES.
REQ-031 Each output SHALL drive one downstream 7-segment decoder directly, with no extra logic.

Verification
REQ-032 The bench SHALL cover "e2e4\n" with TIMEOUT_CYCLES=100 -> the cycle after '\n': from_file=4, from_rank=1, to_file=4, to_rank=3, move_pulse for 1 cycle, move_valid=1.
REQ-033 The bench SHALL cover "G1F3\r\n" -> outputs 6, 0, 5, 2 with exactly one move_pulse and no error pulse.
REQ-034 The bench SHALL cover "e9" after a latched move -> one error pulse, busy=0, and the previous outputs unchanged.
REQ-035 The bench SHALL cover "a1a1\n" -> one error pulse, no move_pulse, and move_valid unchanged.
REQ-036 The bench SHALL cover "e2" then 100 idle cycles (TIMEOUT_CYCLES=100) -> error pulses once, busy=0, and a following "d7d5\n" latches 3, 6, 3, 4.
REQ-037 The bench SHALL cover clear asserted on the commit edge -> outputs all 4'hF, move_valid=0, no move_pulse; and reset asserted after "b1c" -> busy=0 and no error pulse.

Source files
------------

// File: rtl/move_parser_pkg.sv
// Shared definitions for the chess move parser: FSM states, ASCII constants
// and byte classification helpers.
package move_parser_pkg;

   typedef enum logic [2:0] {
      S_FFILE,
      S_FRANK,
      S_TFILE,
      S_TRANK,
      S_TERM
   } state_t;

   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LA    = 8'h61;  // 'a'
   localparam logic [7:0] ASCII_UA    = 8'h41;  // 'A'
   localparam logic [7:0] ASCII_ONE   = 8'h31;  // '1'
   localparam logic [3:0] BLANK_CODE  = 4'hF;

   function automatic logic is_file(input logic [7:0] b);
      return ((b >= ASCII_LA) && (b <= ASCII_LA + 8'd7)) ||
             ((b >= ASCII_UA) && (b <= ASCII_UA + 8'd7));
   endfunction

   function automatic logic is_rank(input logic [7:0] b);
      return (b >= ASCII_ONE) && (b <= ASCII_ONE + 8'd7);
   endfunction

   function automatic logic is_term(input logic [7:0] b);
      return (b == ASCII_LF) || (b == ASCII_CR);
   endfunction

   // 'a', 'A' and '1' all end in 3'b001, so one subtraction on the low bits
   // maps any validated file or rank character to 0-7.
   function automatic logic [2:0] field_code(input logic [2:0] lo);
      return lo - 3'd1;
   endfunction

endpackage

// File: rtl/move_parser_timeout_counter.sv
// Inter-byte idle timer: counts while enabled, restarts on each byte and
// flags expiry on the last allowed idle cycle.
module timeout_counter
   import move_parser_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   assign expired = enable && (count == LAST);

   always_ff @(posedge clock) begin
      if (reset || restart || !enable || expired)
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/move_parser.sv
// Parses ASCII moves such as "e2e4\n" from a serial byte stream and latches
// the from/to squares for the display once a full move is terminated.
module move_parser
   import move_parser_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       clear,
   output logic [3:0] from_file,
   output logic [3:0] from_rank,
   output logic [3:0] to_file,
   output logic [3:0] to_rank,
   output logic       move_valid,
   output logic       move_pulse,
   output logic       error,
   output logic       busy
);

   state_t     state, state_next;
   logic [2:0] sh_ffile, sh_frank, sh_tfile, sh_trank;
   logic       ld_ffile, ld_frank, ld_tfile, ld_trank;
   logic       commit, err, expired;

   assign busy = (state != S_FFILE);

   timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clock  (clock),
      .reset  (reset),
      .enable (busy),
      .restart(rx_valid),
      .expired(expired)
   );

   always_ff @(posedge clock) begin
      if (reset)
         state <= S_FFILE;
      else
         state <= state_next;
   end

   // A received byte always outranks a simultaneous timeout.
   always_comb begin
      state_next = state;
      ld_ffile   = 1'b0;
      ld_frank   = 1'b0;
      ld_tfile   = 1'b0;
      ld_trank   = 1'b0;
      commit     = 1'b0;
      err        = 1'b0;
      if (rx_valid) begin
         case (state)
            S_FFILE: begin
               if (is_file(rx_data)) begin
                  ld_ffile   = 1'b1;
                  state_next = S_FRANK;
               end else if (!is_term(rx_data)) begin
                  err = 1'b1;
               end
            end
            S_FRANK: begin
               if (is_rank(rx_data)) begin
                  ld_frank   = 1'b1;
                  state_next = S_TFILE;
               end else begin
                  err        = 1'b1;
                  state_next = S_FFILE;
               end
            end
            S_TFILE: begin
               if (is_file(rx_data)) begin
                  ld_tfile   = 1'b1;
                  state_next = S_TRANK;
               end else begin
                  err        = 1'b1;
                  state_next = S_FFILE;
               end
            end
            S_TRANK: begin
               if (is_rank(rx_data)) begin
                  ld_trank   = 1'b1;
                  state_next = S_TERM;
               end else begin
                  err        = 1'b1;
                  state_next = S_FFILE;
               end
            end
            S_TERM: begin
               state_next = S_FFILE;
               if (!is_term(rx_data))
                  err = 1'b1;
               else if ((sh_ffile == sh_tfile) && (sh_frank == sh_trank))
                  err = 1'b1;
               else
                  commit = 1'b1;
            end
            default: state_next = S_FFILE;
         endcase
      end else if (expired) begin
         err        = 1'b1;
         state_next = S_FFILE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sh_ffile   <= '0;
         sh_frank   <= '0;
         sh_tfile   <= '0;
         sh_trank   <= '0;
         from_file  <= BLANK_CODE;
         from_rank  <= BLANK_CODE;
         to_file    <= BLANK_CODE;
         to_rank    <= BLANK_CODE;
         move_valid <= 1'b0;
         move_pulse <= 1'b0;
         error      <= 1'b0;
      end else begin
         if (ld_ffile) sh_ffile <= field_code(rx_data[2:0]);
         if (ld_frank) sh_frank <= field_code(rx_data[2:0]);
         if (ld_tfile) sh_tfile <= field_code(rx_data[2:0]);
         if (ld_trank) sh_trank <= field_code(rx_data[2:0]);
         error      <= err;
         move_pulse <= commit && !clear;
         if (clear) begin
            from_file  <= BLANK_CODE;
            from_rank  <= BLANK_CODE;
            to_file    <= BLANK_CODE;
            to_rank    <= BLANK_CODE;
            move_valid <= 1'b0;
         end else if (commit) begin
            from_file  <= {1'b0, sh_ffile};
            from_rank  <= {1'b0, sh_frank};
            to_file    <= {1'b0, sh_tfile};
            to_rank    <= {1'b0, sh_trank};
            move_valid <= 1'b1;
         end
      end
   end

endmodule
